// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned VW_DEFAULT = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StBusy     = 3'b001,
        StFixup    = 3'b010,
        StCalcDone = 3'b100,
        StErr      = 3'b101
    } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned VW = 8
) (
    input  logic [VW-1:0] part_rem,
    input  logic          dvd_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_next,
    output logic          q_bit
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;

    always_comb begin
        shifted = {1'b0, part_rem, dvd_bit};
        trial   = shifted - {2'b00, divisor};
        // Partial remainder stays below the divisor, so either result fits in VW bits.
        q_bit    = ~trial[VW+1];
        rem_next = q_bit ? trial[VW-1:0] : shifted[VW-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 16/8 restoring divider, one quotient bit per clock, start/done handshake.
// SEQ_DIVIDER_SIGNED_EN selects two's-complement operands with one extra sign fix-up cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          done,
    output logic          busy,
    output logic          div_zero,
    output logic [2:0]    state_out
);

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [DW-1:0]      work_q;
    logic [VW-1:0]      dvs_q;
    logic [VW-1:0]      part_rem_q;
    logic               zero_wait_q;

    logic [VW-1:0]      rem_next;
    logic               q_bit;
    logic               accept;
    logic               last_iter;
    logic [DW-1:0]      dvd_in;
    logic [VW-1:0]      dvs_in;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic               neg_q_q;
    logic               neg_r_q;

    // Divide magnitudes; -32768 maps onto itself and reads correctly as unsigned 32768.
    assign dvd_in = dividend[DW-1] ? -dividend : dividend;
    assign dvs_in = divisor[VW-1] ? -divisor : divisor;
`else
    assign dvd_in = dividend;
    assign dvs_in = divisor;
`endif

    assign accept    = start && (state_q == StIdle || state_q == StErr);
    assign last_iter = (count_q == CNT_W'(DW - 1));
    assign state_out = state_q;

    div_step #(
        .VW (VW)
    ) u_div_step (
        .part_rem (part_rem_q),
        .dvd_bit  (work_q[DW-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q     <= StIdle;
            count_q     <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            part_rem_q  <= '0;
            zero_wait_q <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_zero    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                count_q    <= '0;
                part_rem_q <= '0;
                work_q     <= dvd_in;
                dvs_q      <= dvs_in;
                div_zero   <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                neg_q_q    <= dividend[DW-1] ^ divisor[VW-1];
                neg_r_q    <= dividend[DW-1];
`endif
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= '0;
                    zero_wait_q <= 1'b1;
                    state_q     <= StCalcDone;
                end else begin
                    busy    <= 1'b1;
                    state_q <= StBusy;
                end
            end else begin
                case (state_q)
                    StIdle: state_q <= StIdle;
                    StBusy: begin
                        if (start) begin
                            busy    <= 1'b0;
                            state_q <= StErr;
                        end else begin
                            work_q     <= {work_q[DW-2:0], q_bit};
                            part_rem_q <= rem_next;
                            count_q    <= count_q + 1'b1;
                            if (last_iter) begin
                                quotient  <= {work_q[DW-2:0], q_bit};
                                remainder <= rem_next;
                                busy      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                                state_q   <= StFixup;
`else
                                done      <= 1'b1;
                                state_q   <= StCalcDone;
`endif
                            end
                        end
                    end
`ifdef SEQ_DIVIDER_SIGNED_EN
                    StFixup: begin
                        if (neg_q_q) quotient <= -quotient;
                        if (neg_r_q) remainder <= -remainder;
                        done    <= 1'b1;
                        state_q <= StCalcDone;
                    end
`endif
                    StCalcDone: begin
                        // Divide-by-zero lingers one cycle here so done lands one edge after accept.
                        if (zero_wait_q) begin
                            zero_wait_q <= 1'b0;
                            done        <= 1'b1;
                            state_q     <= start ? StErr : StCalcDone;
                        end else begin
                            state_q <= start ? StErr : StIdle;
                        end
                    end
                    StErr:   state_q <= StErr;
                    default: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven self-checking bench for seq_divider (unsigned or SEQ_DIVIDER_SIGNED_EN build).
`timescale 1ns/1ps
module tb_seq_divider;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        done;
    logic        busy;
    logic        div_zero;
    logic [2:0]  state_out;

    int errors = 0;
    int checks = 0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    seq_divider dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .div_zero  (div_zero),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                           input logic [7:0] r, input logic dz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] q, input logic [7:0] r, input logic dz);
        int k;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check({name, " busy"}, {31'd0, busy}, {31'd0, ~dz});
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, k, dz ? 1 : LAT);
        check({name, " quotient"}, {16'd0, quotient}, {16'd0, q});
        check({name, " remainder"}, {24'd0, remainder}, {24'd0, r});
        check({name, " div_zero"}, {31'd0, div_zero}, {31'd0, dz});
        check({name, " state"}, {29'd0, state_out}, 32'd4);
    endtask

    task automatic check_idle_after(input string name, input logic [15:0] q, input logic [7:0] r);
        @(negedge clk);
        check({name, " done pulse"}, {31'd0, done}, 32'd0);
        check({name, " back idle"}, {29'd0, state_out}, 32'd0);
        check({name, " held q"}, {16'd0, quotient}, {16'd0, q});
        check({name, " held r"}, {24'd0, remainder}, {24'd0, r});
    endtask

    initial begin
        int seen;
        reset_a  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

`ifdef SEQ_DIVIDER_SIGNED_EN
        add_vec(16'hFC18, 8'd7,   16'hFF72, 8'hFA, 1'b0); // -1000 / 7
        add_vec(16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0); // -32768 / -1
        add_vec(16'd1000, 8'd7,   16'd142,  8'd6,  1'b0);
        add_vec(16'd100,  8'hF7,  16'hFFF5, 8'd1,  1'b0); // 100 / -9
        add_vec(16'hFF9C, 8'hF7,  16'd11,   8'hFF, 1'b0); // -100 / -9
        add_vec(16'd1234, 8'd0,   16'hFFFF, 8'h00, 1'b1);
        add_vec(16'd12345, 8'd123, 16'd100, 8'd45, 1'b0);
`else
        add_vec(16'd1000,  8'd7,   16'd142,   8'd6,   1'b0);
        add_vec(16'd65535, 8'd255, 16'd257,   8'd0,   1'b0);
        add_vec(16'd1234,  8'd0,   16'hFFFF,  8'h00,  1'b1);
        add_vec(16'd12345, 8'd123, 16'd100,   8'd45,  1'b0);
        add_vec(16'd7,     8'd9,   16'd0,     8'd7,   1'b0);
        add_vec(16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0);
        add_vec(16'd40000, 8'd255, 16'd156,   8'd220, 1'b0);
`endif

        #12;
        check("reset state", {29'd0, state_out}, 32'd0);
        check("reset outputs", {quotient, remainder, 5'd0, done, busy, div_zero}, 32'd0);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
            check_idle_after($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
            if (vecs[i].dz) check("dz sticky", {31'd0, div_zero}, 32'd1);
        end

`ifndef SEQ_DIVIDER_SIGNED_EN
        // Back-to-back: next start right in the idle cycle after done.
        run_op("b2b first", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
        @(negedge clk);
        run_op("b2b second", 16'd0, 8'd5, 16'd0, 8'd0, 1'b0);
        check_idle_after("b2b second", 16'd0, 8'd0);
`endif

        // Abort: start pulsed 5 cycles after accept.
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort state", {29'd0, state_out}, 32'd5);
        check("abort busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort no done", seen, 0);
        check("err holds", {29'd0, state_out}, 32'd5);
        run_op("from err", 16'd100, 8'd9, 16'd11, 8'd1, 1'b0);
        check_idle_after("from err", 16'd11, 8'd1);

        // Asynchronous reset in the middle of an iteration.
        dividend = 16'd50000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid busy", {31'd0, busy}, 32'd1);
        #2 reset_a = 1'b0;
        #1;
        check("async rst state", {29'd0, state_out}, 32'd0);
        check("async rst outputs", {quotient, remainder, 5'd0, done, busy, div_zero}, 32'd0);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        run_op("after reset", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0);
        check_idle_after("after reset", 16'd66, 8'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
